// File: rtl/seq_log_pkg.sv
// Shared types, default sizes and helpers for the sequence event logger.
package seq_log_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMED    = 2'b01,
    HALTED   = 2'b10
  } log_state_e;

  localparam int DEF_TS_W  = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 16;

  // Increment v, holding at the all-ones value of a w-bit counter (w < 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/seq_log_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only when a pop frees the slot.
module seq_log_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is deliberately not reset; validity is tracked by level alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/seq_event_logger.sv
// Timestamps detector pulses into a FWFT FIFO with saturating status counters.
// Optional registered threshold/overflow interrupt when SEQ_LOG_IRQ_EN is defined.
module seq_event_logger
  import seq_log_pkg::*;
#(
  parameter int TS_W         = DEF_TS_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DET_LAT      = 1,
  parameter int STOP_ON_FULL = 0
`ifdef SEQ_LOG_IRQ_EN
  , parameter int IRQ_THRESH = DEPTH / 2
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     disarm,
  input  logic                     detect_in,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [TS_W-1:0]          evt_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         total_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow,
`ifdef SEQ_LOG_IRQ_EN
  output logic                     irq,
`endif
  output logic [1:0]               state_o
);

  localparam int LW = $clog2(DEPTH) + 1;

  log_state_e      state;
  logic [TS_W-1:0] ts_cnt;
  logic            fifo_full;
  logic            fifo_empty;
  logic            logging;
  logic            pop;
  logic            drop;

  assign state_o   = state;
  assign evt_valid = !fifo_empty;
  assign pop       = evt_valid && evt_ready;
  assign logging   = (state == ARMED) && detect_in;
  // A full FIFO only loses the event when nothing leaves in the same cycle.
  assign drop      = logging && fifo_full && !pop;

  seq_log_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (logging),
    .din   (ts_cnt - TS_W'(DET_LAT)),
    .pop   (pop),
    .dout  (evt_ts),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= DISARMED;
      ts_cnt    <= '0;
      total_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        DISARMED: begin
          if (arm && !disarm) begin
            state     <= ARMED;
            ts_cnt    <= '0;
            total_cnt <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
          end
        end
        ARMED: begin
          ts_cnt <= ts_cnt + TS_W'(1);
          if (detect_in) total_cnt <= CNT_W'(sat_inc(64'(total_cnt), CNT_W));
          if (drop) begin
            drop_cnt <= CNT_W'(sat_inc(64'(drop_cnt), CNT_W));
            overflow <= 1'b1;
          end
          if (disarm)                           state <= DISARMED;
          else if (drop && STOP_ON_FULL != 0)   state <= HALTED;
        end
        HALTED: begin
          if (disarm) state <= DISARMED;
        end
        default: state <= DISARMED;
      endcase
    end
  end

`ifdef SEQ_LOG_IRQ_EN
  localparam logic [LW-1:0] IRQ_LVL = LW'(IRQ_THRESH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= (level >= IRQ_LVL) || overflow;
  end
`endif

endmodule

// File: tb/tb_seq_event_logger.sv
// Scoreboard bench: two loggers (16-bit/run-on-full and 4-bit/halt-on-full) share one stimulus stream.
module tb_seq_event_logger;
  import seq_log_pkg::*;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 16;
  localparam int DET_LAT = 1;
  localparam int IRQ_T   = DEPTH / 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic arm = 1'b0, disarm = 1'b0, detect_in = 1'b0, evt_ready = 1'b0;

  logic        valid_a, valid_b, ovf_a, ovf_b;
  logic [15:0] ts_a;
  logic [3:0]  ts_b;
  logic [3:0]  lvl_a, lvl_b;
  logic [15:0] tot_a, tot_b, drp_a, drp_b;
  logic [1:0]  st_a, st_b;
`ifdef SEQ_LOG_IRQ_EN
  logic        irq_a, irq_b;
`endif

  always #5 clk = ~clk;

  seq_event_logger #(.TS_W(16), .DEPTH(DEPTH), .CNT_W(CNT_W), .DET_LAT(DET_LAT), .STOP_ON_FULL(0)) dut_a (
    .clk(clk), .reset(reset), .arm(arm), .disarm(disarm), .detect_in(detect_in),
    .evt_valid(valid_a), .evt_ready(evt_ready), .evt_ts(ts_a), .level(lvl_a),
    .total_cnt(tot_a), .drop_cnt(drp_a), .overflow(ovf_a),
`ifdef SEQ_LOG_IRQ_EN
    .irq(irq_a),
`endif
    .state_o(st_a));

  seq_event_logger #(.TS_W(4), .DEPTH(DEPTH), .CNT_W(CNT_W), .DET_LAT(DET_LAT), .STOP_ON_FULL(1)) dut_b (
    .clk(clk), .reset(reset), .arm(arm), .disarm(disarm), .detect_in(detect_in),
    .evt_valid(valid_b), .evt_ready(evt_ready), .evt_ts(ts_b), .level(lvl_b),
    .total_cnt(tot_b), .drop_cnt(drp_b), .overflow(ovf_b),
`ifdef SEQ_LOG_IRQ_EN
    .irq(irq_b),
`endif
    .state_o(st_b));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: state 0=disarmed, 1=armed, 2=halted; queues hold expected timestamps.
  int m_state [2] = '{0, 0};
  int m_ts    [2] = '{0, 0};
  int m_cnt   [2] = '{0, 0};
  int m_total [2] = '{0, 0};
  int m_drop  [2] = '{0, 0};
  bit m_ovf   [2] = '{0, 0};
  bit m_irq   [2] = '{0, 0};
  int exp_a[$];
  int exp_b[$];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_ts[i] = 0; m_cnt[i] = 0; m_total[i] = 0;
      m_drop[i] = 0; m_ovf[i] = 0; m_irq[i] = 0;
    end
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic model_step(input int i);
    int  mask    = (i == 0) ? 32'hFFFF : 32'hF;
    bit  stop    = (i == 1);
    int  cap     = (1 << CNT_W) - 1;
    bit  pop     = (m_cnt[i] > 0) && evt_ready;
    bit  pushed  = 1'b0;
    bit  dropped = 1'b0;
    m_irq[i] = (m_cnt[i] >= IRQ_T) || m_ovf[i];
    if (m_state[i] == 0) begin
      if (arm && !disarm) begin
        m_state[i] = 1; m_ts[i] = 0; m_total[i] = 0; m_drop[i] = 0; m_ovf[i] = 0;
      end
    end else if (m_state[i] == 1) begin
      if (detect_in) begin
        if (m_total[i] < cap) m_total[i]++;
        if (m_cnt[i] == DEPTH && !pop) begin
          dropped = 1'b1;
          if (m_drop[i] < cap) m_drop[i]++;
          m_ovf[i] = 1'b1;
        end else begin
          pushed = 1'b1;
          if (i == 0) exp_a.push_back((m_ts[i] - DET_LAT) & mask);
          else        exp_b.push_back((m_ts[i] - DET_LAT) & mask);
        end
      end
      m_ts[i] = (m_ts[i] + 1) & mask;
      if (disarm)                 m_state[i] = 0;
      else if (dropped && stop)   m_state[i] = 2;
    end else if (disarm) begin
      m_state[i] = 0;
    end
    m_cnt[i] = m_cnt[i] + int'(pushed) - int'(pop);
  endtask

  task automatic status_check(input int i, input logic [3:0] lvl, input logic v,
                              input logic [15:0] tot, input logic [15:0] drp,
                              input logic ov, input logic [1:0] st);
    check($sformatf("level[%0d]", i),     64'(lvl), 64'(m_cnt[i]));
    check($sformatf("evt_valid[%0d]", i), 64'(v),   64'(m_cnt[i] != 0));
    check($sformatf("total_cnt[%0d]", i), 64'(tot), 64'(m_total[i]));
    check($sformatf("drop_cnt[%0d]", i),  64'(drp), 64'(m_drop[i]));
    check($sformatf("overflow[%0d]", i),  64'(ov),  64'(m_ovf[i]));
    check($sformatf("state[%0d]", i),     64'(st),  64'(m_state[i]));
  endtask

  task automatic hs_check(input int i, input logic v, input logic [15:0] ts);
    int e;
    if (v !== 1'b1 || evt_ready !== 1'b1) return;
    if ((i == 0 && exp_a.size() == 0) || (i == 1 && exp_b.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL pop_unexpected[%0d]: got evt_ts %0d, expected no entry (t=%0t)", i, ts, $time);
      return;
    end
    e = (i == 0) ? exp_a.pop_front() : exp_b.pop_front();
    check($sformatf("evt_ts[%0d]", i), 64'(ts), 64'(e));
  endtask

  // Status monitor: compares post-edge outputs against the model.
  initial forever begin
    @(posedge clk);
    #1;
    if (!reset) begin
      status_check(0, lvl_a, valid_a, tot_a, drp_a, ovf_a, st_a);
      status_check(1, lvl_b, valid_b, tot_b, drp_b, ovf_b, st_b);
`ifdef SEQ_LOG_IRQ_EN
      check("irq[0]", 64'(irq_a), 64'(m_irq[0]));
      check("irq[1]", 64'(irq_b), 64'(m_irq[1]));
`endif
    end
  end

  // Handshake monitor: every accepted head is popped from the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      hs_check(0, valid_a, ts_a);
      hs_check(1, valid_b, {12'd0, ts_b});
    end
  end

  task automatic cyc(input bit a, input bit d, input bit det, input bit rdy);
    @(posedge clk);
    #2;
    arm = a; disarm = d; detect_in = det; evt_ready = rdy;
    model_step(0);
    model_step(1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    arm = 1'b0; disarm = 1'b0; detect_in = 1'b0; evt_ready = 1'b0;
    model_clear();
    #1;
    check("rst_level_a", 64'(lvl_a), 64'd0);
    check("rst_valid_a", 64'(valid_a), 64'd0);
    check("rst_total_a", 64'(tot_a), 64'd0);
    check("rst_drop_a",  64'(drp_a), 64'd0);
    check("rst_ovf_a",   64'(ovf_a), 64'd0);
    check("rst_ts_a",    64'(ts_a),  64'd0);
    check("rst_level_b", 64'(lvl_b), 64'd0);
    check("rst_state_b", 64'(st_b),  64'd0);
`ifdef SEQ_LOG_IRQ_EN
    check("rst_irq_a", 64'(irq_a), 64'd0);
`endif
    #1;
    reset = 1'b0;
    model_step(0);
    model_step(1);
  endtask

  initial begin
    #3;
    check("por_valid", 64'(valid_a), 64'd0);
    check("por_state", 64'(st_a), 64'd0);
    #14;
    reset = 1'b0;

    // Two spaced detects, consumer stalled, then drained.
    cyc(1, 0, 0, 0);
    for (int c = 0; c < 12; c++) cyc(0, 0, (c == 5 || c == 9), 0);
    for (int c = 0; c < 3; c++)  cyc(0, 0, 0, 1);

    // Ten detects into a stalled FIFO: drops (a) and halt (b).
    for (int c = 0; c < 10; c++) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    for (int c = 0; c < 10; c++) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);

    // Simultaneous arm/disarm while disarmed, then a detect at ts_cnt = 0.
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);

    // Five buffered events, then reset mid-operation.
    for (int c = 0; c < 5; c++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    do_reset();

    // Randomized traffic with occasional mid-run resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else cyc($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3,
               $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 40);
    end
    for (int c = 0; c < 12; c++) cyc(0, 0, 0, 1);
    @(posedge clk);
    #3;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
